// File: rtl/ram_fifo_pkg.sv
// Shared constants and output-stage state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 16;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual_port_ram: staged port-A writes, port-B reads into an output register.
// Optional macro RAM_FIFO_CTRL_COUNT_EN adds a registered fill_count output.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] address_a,
  output logic [DATA_W-1:0] data_in_a,
  output logic              write_enable_a,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_out_b
`ifdef RAM_FIFO_CTRL_COUNT_EN
  ,
  output logic [ADDR_W:0]   fill_count
`endif
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic              stage_valid_reg;
  logic [DATA_W-1:0] stage_data_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   committed_reg;
  logic [ADDR_W:0]   committed_next;
  logic [ADDR_W:0]   used_next;
  logic              full_reg;
  out_state_t        state_reg;
  out_state_t        state_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic              accept;
  logic              load;

  assign accept = wr_valid && !full_reg;
  // Only words already written to RAM may be loaded; the staged word is not visible on port B yet.
  assign load   = (committed_reg != '0) && ((state_reg == OUT_EMPTY) || rd_ready);

  always_comb begin
    committed_next = committed_reg;
    if (stage_valid_reg && !load) begin
      committed_next = committed_reg + CNT_ONE;
    end else if (!stage_valid_reg && load) begin
      committed_next = committed_reg - CNT_ONE;
    end
  end

  assign used_next = committed_next + {{ADDR_W{1'b0}}, accept};

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = OUT_VALID;
    end else if ((state_reg == OUT_VALID) && rd_ready) begin
      state_next = OUT_EMPTY;
    end
  end

  // full_reg mirrors used == DEPTH, so a load while full frees a slot only from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_reg <= 1'b0;
      stage_data_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      committed_reg   <= '0;
      full_reg        <= 1'b0;
      state_reg       <= OUT_EMPTY;
      rd_data_reg     <= '0;
    end else begin
      stage_valid_reg <= accept;
      if (accept) begin
        stage_data_reg <= wr_data;
      end
      if (stage_valid_reg) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (load) begin
        rd_data_reg <= data_out_b;
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
      end
      committed_reg <= committed_next;
      full_reg      <= (used_next == CNT_FULL);
      state_reg     <= state_next;
    end
  end

  assign wr_ready       = !full_reg;
  assign rd_valid       = (state_reg == OUT_VALID);
  assign rd_data        = rd_data_reg;
  assign address_a      = wr_ptr_reg;
  assign data_in_a      = stage_data_reg;
  assign write_enable_a = stage_valid_reg;
  assign address_b      = rd_ptr_reg;

`ifdef RAM_FIFO_CTRL_COUNT_EN
  logic [ADDR_W:0] fill_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count_reg <= '0;
    end else begin
      fill_count_reg <= used_next + {{ADDR_W{1'b0}}, (state_next == OUT_VALID)};
    end
  end

  assign fill_count = fill_count_reg;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural dual_port_ram and a queue-based reference model.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready = 1'b0;
  logic [3:0] address_a;
  logic [7:0] data_in_a;
  logic       write_enable_a;
  logic [3:0] address_b;
  logic [7:0] data_out_b;
`ifdef RAM_FIFO_CTRL_COUNT_EN
  logic [4:0] fill_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit run_cmp  = 1'b0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .address_a     (address_a),
    .data_in_a     (data_in_a),
    .write_enable_a(write_enable_a),
    .address_b     (address_b),
    .data_out_b    (data_out_b)
`ifdef RAM_FIFO_CTRL_COUNT_EN
    ,
    .fill_count    (fill_count)
`endif
  );

  // dual_port_ram stand-in: synchronous port-A write, combinational port-B read, port-B writes tied off.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) if (write_enable_a) mem[address_a] <= data_in_a;
  assign data_out_b = mem[address_b];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: words waiting in order, each loadable two edges after acceptance.
  logic [7:0] q_data [$];
  int         q_rdy  [$];
  int         edge_n = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_we = 1'b0;
  logic [7:0] m_wdata = 8'h00;
  int         m_wcnt = 0;
  int         m_rcnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data.delete();
      q_rdy.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_we    = 1'b0;
      m_wcnt  = 0;
      m_rcnt  = 0;
    end else begin
      automatic bit acc = wr_valid && (q_data.size() < 16);
      edge_n++;
      if (m_we) m_wcnt++;
      if (q_data.size() > 0 && q_rdy[0] <= edge_n && (!m_valid || rd_ready)) begin
        m_data  = q_data.pop_front();
        void'(q_rdy.pop_front());
        m_valid = 1'b1;
        m_rcnt++;
      end else if (m_valid && rd_ready) begin
        m_valid = 1'b0;
      end
      m_we = acc;
      if (acc) begin
        m_wdata = wr_data;
        q_data.push_back(wr_data);
        q_rdy.push_back(edge_n + 2);
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("rd_valid", rd_valid, m_valid);
      check("rd_data", rd_data, m_data);
      check("wr_ready", wr_ready, (q_data.size() < 16));
      check("write_enable_a", write_enable_a, m_we);
      check("address_a", address_a, m_wcnt % 16);
      if (m_we) check("data_in_a", data_in_a, m_wdata);
      check("address_b", address_b, m_rcnt % 16);
`ifdef RAM_FIFO_CTRL_COUNT_EN
      check("fill_count", fill_count, q_data.size() + int'(m_valid));
`endif
    end
  end

  logic [7:0] in_log  [$];
  logic [7:0] out_log [$];

  always @(posedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      out_log.push_back(rd_data);
      $display("rd  data=%02h addr_b=%0d t=%0t", rd_data, address_b, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wr_ready is registered, so its value now decides acceptance at the coming edge.
  task automatic offer(input logic [7:0] d);
    automatic bit acc;
    wr_valid = 1'b1;
    wr_data  = d;
    acc      = wr_ready;
    tick();
    if (acc) begin
      in_log.push_back(d);
      $display("wr  data=%02h t=%0t", d, $time);
    end
    wr_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((i % 2) == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && $urandom_range(0, 3) == 0) tick();
      else offer(8'($urandom));
    end
  endtask

  task automatic wait_drain();
    automatic int guard = 0;
    rd_ready = 1'b1;
    while ((q_data.size() != 0 || m_valid || m_we) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic compare_logs(input string name);
    check({name, "_count"}, out_log.size(), in_log.size());
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
      check({name, "_order"}, out_log[i], in_log[i]);
    in_log.delete();
    out_log.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_cmp = 1'b1;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_we_a", write_enable_a, 0);
    check("reset_address_a", address_a, 0);
    check("reset_data_in_a", data_in_a, 0);
    check("reset_wr_ready", wr_ready, 1);

    // Single word: write at the next cycle, visible on the output two edges after acceptance.
    rd_ready = 1'b1;
    offer(8'hAA);
    check("single_we", write_enable_a, 1);
    check("single_addr_a", address_a, 0);
    check("single_data_a", data_in_a, 8'hAA);
    check("single_valid_early", rd_valid, 0);
    tick();
    check("single_we_once", write_enable_a, 0);
    check("single_valid_n1", rd_valid, 0);
    tick();
    check("single_valid_n2", rd_valid, 1);
    check("single_data", rd_data, 8'hAA);
    wait_drain();
    compare_logs("single");

    // Fill with the consumer stalled: 16 in RAM/staging plus one in the output register.
    rd_ready = 1'b0;
    begin
      automatic int got = 0;
      automatic int guard = 0;
      while (got < 17 && guard < 100) begin
        if (wr_ready) begin
          offer(8'(got));
          got++;
        end else tick();
        guard++;
      end
      check("fill_accepts", got, 17);
    end
    tick();
    check("full_wr_ready", wr_ready, 0);
    check("full_rd_valid", rd_valid, 1);
    check("full_rd_data", rd_data, 8'h00);
`ifdef RAM_FIFO_CTRL_COUNT_EN
    check("full_fill_count", fill_count, 17);
`endif
    repeat (3) begin
      offer(8'hEE);
      check("full_ignored", wr_ready, 0);
    end
    wait_drain();
    check("fill_drain_count", out_log.size(), 17);
    for (int i = 0; i < 17 && i < out_log.size(); i++) check("fill_drain_value", out_log[i], i);
`ifdef RAM_FIFO_CTRL_COUNT_EN
    check("drained_fill_count", fill_count, 0);
`endif
    compare_logs("fill");

    // Wrap: 40 words streaming with the consumer always ready.
    stream(40, 0);
    check("wrap_accepts", in_log.size(), 40);
    wait_drain();
    compare_logs("wrap");

    // Backpressure: rd_ready alternating during a stream.
    stream(60, 1);
    wait_drain();
    compare_logs("backpressure");

    // Reset mid-operation with words queued and a write staged.
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) offer(8'(8'h30 + i));
    check("pre_reset_staged", write_enable_a, 1);
    rst = 1'b1;
    #1;
    check("reset_we_drop", write_enable_a, 0);
    check("reset_mid_valid", rd_valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_reset_wr_ready", wr_ready, 1);
    check("post_reset_addr_b", address_b, 0);
    check("post_reset_addr_a", address_a, 0);
    in_log.delete();
    out_log.delete();
    rd_ready = 1'b1;
    offer(8'h5C);
    wait_drain();
    check("post_reset_word_count", out_log.size(), 1);
    if (out_log.size() > 0) check("post_reset_word", out_log[0], 8'h5C);
    compare_logs("post_reset");

    // Random traffic on both sides.
    stream(400, 2);
    wait_drain();
    compare_logs("random");

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 4, RAM address width; depth = 2**ADDR_W = 16.
REQ-002 SHALL take parameter DATA_W, default 8, RAM/stream data width.
REQ-003 SHALL have these ports (name, direction, width, meaning); clock and reset come first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  upstream word offered.
- wr_data  in  DATA_W  upstream word.
- wr_ready  out  1  controller can accept.
- rd_valid  out  1  output word present.
- rd_data  out  DATA_W  output word.
- rd_ready  in  1  downstream consumes.
- address_a  out  ADDR_W  dual_port_ram write address.
- data_in_a  out  DATA_W  dual_port_ram write data.
- write_enable_a  out  1  dual_port_ram write strobe.
- address_b  out  ADDR_W  dual_port_ram read address.
- data_out_b  in  DATA_W  dual_port_ram read data (combinational from address_b).
REQ-004 SHALL tie off dual_port_ram port-B writes in the parent (data_in_b = 0, write_enable_b = 0); the controller drives no port-B write signals.

Function
REQ-005 SHALL accept a word on a cycle where wr_valid && wr_ready.
REQ-006 SHALL drive wr_ready = (used < 16), where used = staged write + committed RAM words; wr_ready is independent of wr_valid.
REQ-007 SHALL stage each accepted word for one cycle: on the following cycle, write_enable_a = 1, address_a = wr_ptr, data_in_a = staged word; wr_ptr increments modulo 16 at the end of that cycle.
REQ-008 SHALL hold write_enable_a high for exactly one cycle per accepted word, with address_a and data_in_a stable for that whole cycle.
REQ-009 SHALL drive address_b = rd_ptr continuously.
REQ-010 SHALL run the output stage as a 2-state FSM, OUT_EMPTY and OUT_VALID; rd_valid = (state == OUT_VALID).
REQ-011 SHALL load rd_data <= data_out_b and increment rd_ptr modulo 16 when committed > 0 && (state == OUT_EMPTY || rd_ready); the next state is OUT_VALID.
REQ-012 SHALL go OUT_VALID -> OUT_EMPTY when rd_ready is high and committed == 0.
REQ-013 SHALL hold rd_data stable while rd_valid && !rd_ready.
REQ-014 SHALL have a minimum accept-to-rd_valid latency of 2 cycles (accept at N, RAM write at N+1, rd_valid at N+2); there is no bypass path.
REQ-015 SHALL make committed increment on the write_enable_a cycle and decrement on an output load; simultaneous increment and decrement leaves committed unchanged.
REQ-016 SHALL, when used == 16, hold wr_ready low and ignore wr_valid.
REQ-017 SHALL, on a cycle with an output load while used == 16, not raise wr_ready until the next cycle (registered full flag).
REQ-018 SHALL wrap pointers 15 -> 0 with no lost or duplicated words.
REQ-019 SHALL deliver words in strict acceptance order; total capacity is 16 (RAM/staging) + 1 (output register).

Reset
REQ-020 SHALL reset asynchronously on rst high: wr_ptr = rd_ptr = 0, used = committed = 0, staging empty, state = OUT_EMPTY.
REQ-021 SHALL drive these outputs during and directly after reset: rd_valid = 0, rd_data = 0, write_enable_a = 0, address_a = 0, data_in_a = 0, wr_ready = 1 (after release).
REQ-022 SHALL, on reset mid-operation, discard all in-flight words including a staged write; write_enable_a drops immediately and RAM contents are not cleared.

Configuration
REQ-023 SHALL, when macro RAM_FIFO_CTRL_COUNT_EN is defined, add output fill_count [ADDR_W+1] = used + rd_valid, range 0..17, registered, reset 0.
REQ-024 SHALL, when RAM_FIFO_CTRL_COUNT_EN is not defined, have no fill_count port and no added logic; all other behaviour is identical.

Structure
REQ-025 SHALL take from package ram_fifo_pkg the constants ADDR_W_DEF = 4, DATA_W_DEF = 8, DEPTH = 16, and the enum out_state_t {OUT_EMPTY, OUT_VALID}.
REQ-026 SHALL have no sub-module; the parent instantiates dual_port_ram beside the controller.

Verification
REQ-027 SHALL cover these scenarios, each run with the controller connected to dual_port_ram:
- Single word: write 8'hAA with rd_ready = 1 -> write_enable_a for one cycle at address_a = 0; rd_valid 2 cycles after accept with rd_data = 8'hAA.
- Fill: 17 writes 8'h00..8'h10 with rd_ready = 0 -> wr_ready low after 17 accepts (16 used + output); wr_valid ignored while full; drain returns 00..10 in order.
- Wrap: 40 words streamed with rd_ready = 1 -> address_a and address_b wrap 15 -> 0; output sequence equals input sequence.
- Backpressure: rd_ready toggled 1010... during a stream -> rd_data stable while stalled; no loss or duplication.
- Reset: rst pulsed with 5 words queued and a write staged -> rd_valid = 0, wr_ready = 1, the next word is read from address 0.
- With RAM_FIFO_CTRL_COUNT_EN defined: fill_count tracks 0 -> 17 -> 0 across fill and drain.
